// File: rtl/serial_in_port.sv
// Serial input port: receives start + 12 data bits (LSB first) + stop frames on rx,
// holds the last accepted word on out and raises rdy until the CPU acknowledges it.
module serial_in_port #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        rx,
  input  logic        ack,
  output logic [11:0] out,
  output logic        rdy,
  output logic        ovr,
  output logic        ferr
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CntLast = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CntHalf = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic            rs_prev_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      idx_q, idx_d;
  logic [11:0]     shreg_q, shreg_d;
  logic [11:0]     out_q, out_d;
  logic            rdy_q, rdy_d;
  logic            ovr_q, ovr_d;
  logic            ferr_q, ferr_d;
  logic            rs;

  assign rs = sync_q[1];

  // Synchronizer and edge-detect history reset to the idle-high line level.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync_q    <= 2'b11;
      rs_prev_q <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      out_q     <= '0;
      rdy_q     <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx};
      rs_prev_q <= rs;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      out_q     <= out_d;
      rdy_q     <= rdy_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    out_d   = out_q;
    rdy_d   = rdy_q;
    ovr_d   = ovr_q;
    ferr_d  = ferr_q;

    // Ack clears first; a word completing on the same edge overrides below.
    if (ack) begin
      rdy_d  = 1'b0;
      ovr_d  = 1'b0;
      ferr_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (rs_prev_q && !rs) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          if (!rs) begin
            state_d = StData;
            idx_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d          = '0;
          shreg_d[idx_q] = rs;
          if (idx_q == 4'd11) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (!rs) begin
            ferr_d = 1'b1;
          end else if (!rdy_q || ack) begin
            out_d = shreg_q;
            rdy_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign out  = out_q;
  assign rdy  = rdy_q;
  assign ovr  = ovr_q;
  assign ferr = ferr_q;

endmodule

// File: tb/tb_serial_in_port.sv
// Bench for serial_in_port: frame-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_serial_in_port;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        rx  = 1'b1;
  logic        ack = 1'b0;
  logic [11:0] out;
  logic        rdy, ovr, ferr;

  int total = 0;
  int bad   = 0;

  // Frame-level model: a word lands 219 edges after the edge preceding the rx fall
  // (3 edges of synchronizer/edge detect to E0, then 8 + 13*16).
  logic [11:0] m_out  = '0;
  logic        m_rdy  = 1'b0;
  logic        m_ovr  = 1'b0;
  logic        m_ferr = 1'b0;
  logic        pending = 1'b0;
  int          stop_cnt = 0;
  logic [11:0] p_data = '0;
  logic        p_stop = 1'b1;
  logic        started = 1'b0;
  int          rise;

  always #5 clk = ~clk;

  serial_in_port #(.CLKS_PER_BIT(16)) dut (
    .clk  (clk),
    .clr  (clr),
    .rx   (rx),
    .ack  (ack),
    .out  (out),
    .rdy  (rdy),
    .ovr  (ovr),
    .ferr (ferr)
  );

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge clr) begin
    logic old_rdy;
    if (!clr) begin
      m_out   = '0;
      m_rdy   = 1'b0;
      m_ovr   = 1'b0;
      m_ferr  = 1'b0;
      pending = 1'b0;
    end else begin
      old_rdy = m_rdy;
      if (ack) begin
        m_rdy  = 1'b0;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
      end
      if (pending) begin
        stop_cnt--;
        if (stop_cnt == 0) begin
          pending = 1'b0;
          if (!p_stop) m_ferr = 1'b1;
          else if (!old_rdy || ack) begin
            m_out = p_data;
            m_rdy = 1'b1;
          end else m_ovr = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model out", out, m_out);
      chk("model rdy", {11'b0, rdy}, {11'b0, m_rdy});
      chk("model ovr", {11'b0, ovr}, {11'b0, m_ovr});
      chk("model ferr", {11'b0, ferr}, {11'b0, m_ferr});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
  endtask

  // ack_mode: 0 none, 1 ack on the stop-sample edge, 2 ack two edges after it.
  task automatic send_frame(input logic [11:0] d, input logic stop, input int ack_mode,
                            output int rise_at);
    logic [13:0] fr;
    fr       = {stop, d, 1'b0};
    p_data   = d;
    p_stop   = stop;
    stop_cnt = 219;
    pending  = 1'b1;
    rise_at  = -1;
    for (int c = 0; c < 224; c++) begin
      rx  = fr[c / 16];
      ack = (ack_mode == 1 && c == 218) || (ack_mode == 2 && c == 220);
      @(posedge clk);
      #1;
      if (rdy && rise_at < 0) rise_at = c + 1;
    end
    ack = 1'b0;
  endtask

  initial begin
    logic [13:0] afr;
    #2;
    clr = 1'b0;
    started = 1'b1;
    idle(4);
    clr = 1'b1;
    idle(5);
    chk("reset out", out, 12'h000);
    chk("reset flags", {9'b0, rdy, ovr, ferr}, 12'h000);

    // Single word, exact rdy timing, then ack
    send_frame(12'hA5C, 1'b1, 0, rise);
    chk("a5c rdy edge", 12'(rise), 12'd219);
    chk("a5c out", out, 12'hA5C);
    chk("a5c rdy", {11'b0, rdy}, 12'h001);
    pulse_ack();
    chk("a5c ack rdy", {11'b0, rdy}, 12'h000);
    chk("a5c ack out", out, 12'hA5C);
    idle(10);

    // Glitch shorter than half a bit
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(30);
    chk("glitch out", out, 12'hA5C);
    chk("glitch flags", {9'b0, rdy, ovr, ferr}, 12'h000);
    send_frame(12'h0FF, 1'b1, 0, rise);
    chk("0ff out", out, 12'h0FF);
    chk("0ff rdy", {11'b0, rdy}, 12'h001);
    idle(5);

    // Framing error
    pulse_ack();
    send_frame(12'h7E1, 1'b0, 0, rise);
    rx = 1'b1;
    idle(5);
    chk("ferr flags", {9'b0, rdy, ovr, ferr}, 12'h001);
    chk("ferr out", out, 12'h0FF);
    pulse_ack();
    chk("ferr cleared", {11'b0, ferr}, 12'h000);
    idle(5);

    // Overrun, then ack coinciding with the stop sample
    send_frame(12'h111, 1'b1, 0, rise);
    idle(5);
    send_frame(12'h222, 1'b1, 0, rise);
    idle(5);
    chk("ovr out", out, 12'h111);
    chk("ovr flags", {9'b0, rdy, ovr, ferr}, 12'h006);
    pulse_ack();
    chk("ovr cleared", {9'b0, rdy, ovr, ferr}, 12'h000);
    send_frame(12'h333, 1'b1, 1, rise);
    chk("simul out", out, 12'h333);
    chk("simul flags", {9'b0, rdy, ovr, ferr}, 12'h004);

    // Back-to-back frames, acked after each
    pulse_ack();
    send_frame(12'hFFF, 1'b1, 2, rise);
    chk("b2b fff", out, 12'hFFF);
    send_frame(12'h000, 1'b1, 2, rise);
    chk("b2b 000", out, 12'h000);
    send_frame(12'h800, 1'b1, 2, rise);
    chk("b2b 800", out, 12'h800);
    chk("b2b flags", {9'b0, rdy, ovr, ferr}, 12'h000);
    idle(5);

    // Reset in the middle of a frame, after bit 5
    afr = {1'b1, 12'h5A5, 1'b0};
    for (int c = 0; c < 112; c++) begin
      rx = afr[c / 16];
      @(posedge clk);
      #1;
    end
    clr = 1'b0;
    rx  = 1'b1;
    #1;
    chk("midreset out", out, 12'h000);
    chk("midreset flags", {9'b0, rdy, ovr, ferr}, 12'h000);
    idle(5);
    clr = 1'b1;
    idle(5);
    send_frame(12'h123, 1'b1, 0, rise);
    chk("post reset out", out, 12'h123);
    chk("post reset rdy", {11'b0, rdy}, 12'h001);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_in_port.md
# serial_in_port

Serial input port for the SAP2 mini. Receives 12-bit words from an external device over a single asynchronous line: one start bit, 12 data bits LSB first, one stop bit. Each completed word is held on a parallel output that feeds the input register's data input, and a ready flag is raised for the CPU to poll. The CPU's load of the input register acknowledges the word, making this block the inbound counterpart of the output port.

## Interface
Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; even, ≥ 4.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  reset, asynchronous, active-low.
- rx  in  1  serial line; idles high; asynchronous to clk.
- ack  in  1  word consumed; driven by the input register's load strobe; sampled on the rising edge of clk.
- out  out  12  last accepted word; goes to the input register's data input.
- rdy  out  1  a valid, unacknowledged word is on out.
- ovr  out  1  sticky overrun: a word arrived while rdy was set.
- ferr  out  1  sticky framing error: stop bit sampled low.

## Operation
- rx passes through a 2-flop synchronizer; both flops reset to 1. All logic below uses the synchronized value, rs.
- The state machine has four states: IDLE, START, DATA, STOP. A counter (cnt) runs to CLKS_PER_BIT−1, and a bit index (idx) runs 0..11.
- IDLE: a falling edge on rs (previous 1, current 0) moves to START and clears cnt.
- START: at cnt = CLKS_PER_BIT/2−1, sample rs.
  - rs = 0: go to DATA; clear cnt and idx.
  - rs = 1: the edge was a glitch; return to IDLE with no flag change.
- DATA: at each cnt = CLKS_PER_BIT−1, shift rs into bit idx of the shift register and increment idx. After bit 11, go to STOP.
- STOP: at cnt = CLKS_PER_BIT−1, sample rs.
  - rs = 1 and (rdy = 0 or ack = 1): load out with the shift register and set rdy = 1.
  - rs = 1, rdy = 1, ack = 0: discard the new word; out is unchanged; set ovr.
  - rs = 0: discard the word; set ferr.
  - In all three cases, return to IDLE. A new frame needs a fresh 1→0 edge on rs, so a stuck-low line is never received as a word.
- ack = 1 on an edge clears rdy, ovr and ferr. The exception is a simultaneous word completion: the word is loaded and rdy stays 1.
- ack with rdy = 0 is harmless; it only clears the sticky flags.
- Reset (clr low), at any time including mid-frame:
  - out = 0, rdy = 0, ovr = 0, ferr = 0.
  - State = IDLE; cnt, idx and the shift register are 0.
  - After release, a partially received frame is ignored until the next falling edge.

## Timing
- E0: the clk edge at which IDLE detects the rs falling edge. This is 2–3 edges after rx falls, because of the synchronizer.
- Start-bit check: E0 + CLKS_PER_BIT/2.
- Data bit k (k = 0..11): sampled at E0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
- Stop bit: sampled at E0 + CLKS_PER_BIT/2 + 13·CLKS_PER_BIT. out, rdy, ovr and ferr update on that same edge and are registered outputs.
- Back-to-back frames are accepted: the earliest next start edge can be detected one cycle after the stop sample.
- Tolerated rate mismatch: about ±3 % with CLKS_PER_BIT = 16.
- rdy clears on the edge where ack is sampled high; there is no combinational path from ack to any output.

## Test plan
CLKS_PER_BIT = 16 for all scenarios.
- Reset: assert clr low mid-frame (after bit 5) → out = 0x000, rdy = ovr = ferr = 0 immediately. Release, then send 0x123 → out = 0x123, rdy = 1. No corruption from the aborted frame.
- Single word: send 0xA5C → rdy rises exactly at E0 + 216 and out = 0xA5C. Pulse ack for one cycle → rdy = 0 on the next edge; out holds 0xA5C.
- Glitch: rx low for 4 cycles, then high → state returns to IDLE; rdy, out and ferr unchanged. A following frame 0x0FF is received correctly.
- Framing error: send 0x7E1 with the stop bit low → ferr = 1, rdy = 0, out unchanged. ack clears ferr.
- Overrun and simultaneous ack:
  - Send 0x111 without ack, then send 0x222 → out = 0x111, rdy = 1, ovr = 1.
  - Ack, then send 0x333 with ack asserted on the stop-sample edge → out = 0x333, rdy = 1, ovr = 0.
- Back-to-back: send 0xFFF, 0x000, 0x800 with no idle gap, acking after each → out sequence is 0xFFF, 0x000, 0x800; no ovr or ferr.
